// File: rtl/fsm_rdm_pkg.sv
// Shared definitions for the input-buffer writer and reader FSMs:
// LLR/word geometry, one-hot state constants and the write payload.
package fsm_rdm_pkg;

  localparam int unsigned LLR_WIDTH   = 6;
  localparam int unsigned LANES       = 16;
  localparam int unsigned WORD_WIDTH  = 96;
  localparam int unsigned LANE_BITS   = 4;
  localparam int unsigned CNT_WIDTH   = 14;
  localparam int unsigned ADDR_WIDTH  = 16;
  localparam int unsigned IDX_WIDTH   = 4;
  localparam int unsigned SHIFT_WIDTH = 7;
  localparam int unsigned STATE_WIDTH = 8;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE     = 8'b0000_0001,
    ST_COLLECT  = 8'b0000_0010,
    ST_REQUEST  = 8'b0000_0100,
    ST_WAITCOMP = 8'b0000_1000
  } state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] data;
  } ibw_wr_t;

endpackage

// File: rtl/fsm_ibw_if.sv
// LLR input, input-buffer write port and reader handshake of fsm_ibw.
interface fsm_ibw_if;
  import fsm_rdm_pkg::*;

  logic                  i_Combine_user_start;
  logic [IDX_WIDTH-1:0]  i_Combine_user_index;
  logic [CNT_WIDTH-1:0]  i_Current_Combine_E01_Size;
  logic                  i_LLR_Valid;
  logic [LLR_WIDTH-1:0]  i_LLR_Data;
  logic                  o_LLR_Ready;
  logic                  o_Input_Buffer_Wr_Enable;
  logic [ADDR_WIDTH-1:0] o_Input_Buffer_Wr_Address;
  logic [WORD_WIDTH-1:0] o_Input_Buffer_Wr_Data;
  logic                  o_Combine_process_request;
  logic [IDX_WIDTH-1:0]  o_Combine_user_index;
  logic                  i_RDM_Data_Comp;
  logic                  o_Busy;

  modport slave (
    input  i_Combine_user_start, i_Combine_user_index, i_Current_Combine_E01_Size,
           i_LLR_Valid, i_LLR_Data, i_RDM_Data_Comp,
    output o_LLR_Ready, o_Input_Buffer_Wr_Enable, o_Input_Buffer_Wr_Address,
           o_Input_Buffer_Wr_Data, o_Combine_process_request, o_Combine_user_index, o_Busy
  );

  modport master (
    output i_Combine_user_start, i_Combine_user_index, i_Current_Combine_E01_Size,
           i_LLR_Valid, i_LLR_Data, i_RDM_Data_Comp,
    input  o_LLR_Ready, o_Input_Buffer_Wr_Enable, o_Input_Buffer_Wr_Address,
           o_Input_Buffer_Wr_Data, o_Combine_process_request, o_Combine_user_index, o_Busy
  );

endinterface

// File: rtl/fsm_ibw_llr_packer.sv
// Packs accepted LLRs into 16-lane words; flags a finished word and
// clears the accumulator after it so words never share stale bits.
module llr_packer
  import fsm_rdm_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  accept_i,
  input  logic [LANE_BITS-1:0]  lane_i,
  input  logic [LLR_WIDTH-1:0]  llr_i,
  input  logic                  last_i,
  output logic [WORD_WIDTH-1:0] word_c_o,
  output logic                  done_c_o
);

  logic [WORD_WIDTH-1:0]  acc_q, acc_d;
  logic [SHIFT_WIDTH-1:0] shamt_c;

  assign shamt_c  = SHIFT_WIDTH'(lane_i) * SHIFT_WIDTH'(LLR_WIDTH);
  assign word_c_o = acc_q | (WORD_WIDTH'(llr_i) << shamt_c);
  assign done_c_o = accept_i && (last_i || (lane_i == LANE_BITS'(LANES - 1)));

  always_comb begin
    acc_d = acc_q;
    if (clear_i || done_c_o) begin
      acc_d = '0;
    end else if (accept_i) begin
      acc_d = word_c_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fsm_ibw.sv
// Input-buffer writer: collects one user's LLRs into packed RAM words,
// then requests the reader and waits for its completion pulse.
module fsm_ibw
  import fsm_rdm_pkg::*;
(
  input logic      i_core_clk,
  input logic      i_rx_rstn,
  fsm_ibw_if.slave bus
);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   size_q, cnt_q;
  logic [IDX_WIDTH-1:0]   idx_q;
  logic                   ready_q, busy_q, req_q, wr_en_q;
  ibw_wr_t                wr_q;
  logic                   start_c, accept_c, last_c, done_c;
  logic [WORD_WIDTH-1:0]  word_c;

  assign start_c  = bus.i_Combine_user_start && (state_q == ST_IDLE);
  assign accept_c = bus.i_LLR_Valid && (state_q == ST_COLLECT);
  assign last_c   = (cnt_q == size_q);

  llr_packer u_packer (
    .clk_i    (i_core_clk),
    .rst_ni   (i_rx_rstn),
    .clear_i  (start_c),
    .accept_i (accept_c),
    .lane_i   (cnt_q[LANE_BITS-1:0]),
    .llr_i    (bus.i_LLR_Data),
    .last_i   (last_c),
    .word_c_o (word_c),
    .done_c_o (done_c)
  );

  // Next-state logic; unknown encodings recover to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_c) state_d = ST_COLLECT;
      ST_COLLECT:  if (accept_c && last_c) state_d = ST_REQUEST;
      ST_REQUEST:  state_d = ST_WAITCOMP;
      ST_WAITCOMP: if (bus.i_RDM_Data_Comp) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched user context, LLR counter and registered outputs.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      size_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      wr_en_q <= 1'b0;
      wr_q    <= '0;
    end else begin
      if (start_c) begin
        size_q <= bus.i_Current_Combine_E01_Size;
        idx_q  <= bus.i_Combine_user_index;
        cnt_q  <= '0;
      end else if (accept_c) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      ready_q <= (state_d == ST_COLLECT);
      busy_q  <= (state_d != ST_IDLE);
      req_q   <= (state_q == ST_REQUEST);
      wr_en_q <= done_c;
      if (done_c) begin
        wr_q.addr <= ADDR_WIDTH'(cnt_q[CNT_WIDTH-1:LANE_BITS]);
        wr_q.data <= word_c;
      end
    end
  end

  assign bus.o_LLR_Ready               = ready_q;
  assign bus.o_Busy                    = busy_q;
  assign bus.o_Combine_process_request = req_q;
  assign bus.o_Combine_user_index      = idx_q;
  assign bus.o_Input_Buffer_Wr_Enable  = wr_en_q;
  assign bus.o_Input_Buffer_Wr_Address = wr_q.addr;
  assign bus.o_Input_Buffer_Wr_Data    = wr_q.data;

endmodule
